// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and helpers for the keypad scan/debounce front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Rows 0-2 carry digits 1-9 left to right; row 3 is {*, 0, #}.
  function automatic logic [3:0] kp_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix and key-event signals between the scanner and its neighbours.
interface keypad_scan_debounce_if;
  logic [2:0] col;
  logic [3:0] r_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input col, output r_sel, output key_code, output key_valid, output key_held);
  modport slave  (output col, input r_sel, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scan_debounce_col_sync.sv
// Two-flop synchronizer for asynchronous inputs; idles at all-ones (released).
module col_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops to settle metastability before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x3 keypad row scanner with press/release debounce; one event per physical press.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 12000,
  parameter int DB_CYCLES = 240000
) (
  input  logic                   int_osc,
  input  logic                   reset,
  keypad_scan_debounce_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

  kp_state_t     state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] db_q, db_d;
  logic [2:0]    pat_q, pat_d;
  logic [1:0]    colidx_q, colidx_d;
  logic [3:0]    r_sel_q, code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d;
  logic          accept;
  logic          one_low;
  logic [1:0]    hit_idx;
  logic [2:0]    col_s;

  col_sync #(.W(3)) u_col_sync (
    .clk   (int_osc),
    .rst_n (reset),
    .d     (kp.col),
    .q     (col_s)
  );

  // State register: FSM, counters and all registered outputs.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q  <= SCAN;
      row_q    <= 2'd0;
      dwell_q  <= '0;
      db_q     <= '0;
      pat_q    <= 3'b111;
      colidx_q <= 2'd0;
      r_sel_q  <= 4'b1110;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      dwell_q  <= dwell_d;
      db_q     <= db_d;
      pat_q    <= pat_d;
      colidx_q <= colidx_d;
      r_sel_q  <= ~(4'b0001 << row_d);
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  // Next state: scan dwell, press/release debounce, row advance on exit.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    db_d     = db_q;
    pat_d    = pat_q;
    colidx_d = colidx_q;
    accept   = 1'b0;
    one_low  = 1'b1;
    hit_idx  = 2'd0;
    case (col_s)
      3'b110:  hit_idx = 2'd0;
      3'b101:  hit_idx = 2'd1;
      3'b011:  hit_idx = 2'd2;
      default: one_low = 1'b0;
    endcase
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            state_d  = DEBOUNCE;
            pat_d    = col_s;
            colidx_d = hit_idx;
            db_d     = '0;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s == pat_q) begin
          if (db_q == DB_LAST) begin
            state_d = HELD;
            db_d    = '0;
            accept  = 1'b1;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
          db_d    = '0;
        end
      end
      HELD: begin
        if (col_s == 3'b111) begin
          state_d = RELEASE_DB;
          db_d    = '0;
        end
      end
      default: begin
        if (col_s == 3'b111) begin
          if (db_q == DB_LAST) begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
            dwell_d = '0;
            db_d    = '0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          state_d = HELD;
          db_d    = '0;
        end
      end
    endcase
  end

  // Output decode: strobe and code on acceptance, held while a key is down.
  always_comb begin
    valid_d = accept;
    held_d  = (state_d == HELD) || (state_d == RELEASE_DB);
    code_d  = accept ? kp_decode(row_q, colidx_q) : code_q;
  end

  assign kp.r_sel     = r_sel_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad matrix model, scoreboard of expected key events.
module tb_keypad_scan_debounce;

  logic clk = 1'b0;
  logic reset;
  logic [11:0] pressed;
  logic [2:0]  col_m;
  int n_cmp = 0;
  int n_fail = 0;
  int ev_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  keypad_scan_debounce_if kif();

  keypad_scan_debounce #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
    .int_osc (clk),
    .reset   (reset),
    .kp      (kif)
  );

  // Keypad matrix: a pressed key shorts its row line to its column line.
  always_comb begin
    col_m = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !kif.r_sel[r]) col_m[c] = 1'b0;
  end
  assign kif.col = col_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    check("r_sel_one_low", 32'($countones(~kif.r_sel)), 32'd1);
    if (kif.key_valid === 1'b1) begin
      ev_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got code %0h expected no event at %0t", kif.key_code, $time);
      end else begin
        check("event_code", kif.key_code, exp_q.pop_front());
      end
    end
  end

  task automatic set_key(input int idx, input logic v);
    @(posedge clk);
    #1 pressed[idx] = v;
  endtask

  task automatic wait_event(input int base, input int bound, input string name);
    int n;
    n = 0;
    while (ev_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_event_seen"}, 32'(ev_cnt > base), 32'd1);
  endtask

  task automatic wait_held_low(input int bound, input string name);
    int n;
    n = 0;
    while (kif.key_held !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_held_low"}, kif.key_held, 32'd0);
  endtask

  task automatic check_drop(input string name);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check({name, "_held_before_drop"}, kif.key_held, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({name, "_held_dropped"}, kif.key_held, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, idx, run, n;
    tbl[0]  = '{1, 1, 4'h5};
    tbl[1]  = '{0, 0, 4'h1};
    tbl[2]  = '{0, 1, 4'h2};
    tbl[3]  = '{0, 2, 4'h3};
    tbl[4]  = '{1, 0, 4'h4};
    tbl[5]  = '{1, 2, 4'h6};
    tbl[6]  = '{2, 0, 4'h7};
    tbl[7]  = '{2, 1, 4'h8};
    tbl[8]  = '{2, 2, 4'h9};
    tbl[9]  = '{3, 0, 4'hE};
    tbl[10] = '{3, 1, 4'h0};
    tbl[11] = '{3, 2, 4'hF};

    pressed = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_r_sel", kif.r_sel, 32'hE);
    check("rst_key_code", kif.key_code, 32'h0);
    check("rst_key_valid", kif.key_valid, 32'd0);
    check("rst_key_held", kif.key_held, 32'd0);
    reset = 1'b1;

    // Clean press/hold/release of every key.
    for (int i = 0; i < 12; i++) begin
      base = ev_cnt;
      idx = tbl[i].row * 3 + tbl[i].col;
      exp_q.push_back(tbl[i].code);
      set_key(idx, 1'b1);
      wait_event(base, 200, "tbl_press");
      @(negedge clk);
      check("tbl_held", kif.key_held, 32'd1);
      check("tbl_code", kif.key_code, tbl[i].code);
      repeat (30) @(posedge clk);
      check("tbl_single_event", ev_cnt, base + 1);
      set_key(idx, 1'b0);
      check_drop("tbl");
    end

    // '#' with three 2-cycle bounces while its row is being scanned.
    base = ev_cnt;
    n = 0;
    while (kif.r_sel !== 4'b0111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bounce_row3_reached", kif.r_sel, 32'h7);
    exp_q.push_back(4'hF);
    for (int b = 0; b < 3; b++) begin
      set_key(11, 1'b1);
      @(posedge clk);
      set_key(11, 1'b0);
      @(posedge clk);
    end
    set_key(11, 1'b1);
    wait_event(base, 200, "bounce_press");
    repeat (20) @(posedge clk);
    check("bounce_single_event", ev_cnt, base + 1);
    check("bounce_code", kif.key_code, 32'hF);
    set_key(11, 1'b0);
    wait_held_low(100, "bounce");

    // '7' held, then release bounce: high 3 cycles, low 2, then high.
    base = ev_cnt;
    exp_q.push_back(4'h7);
    set_key(6, 1'b1);
    wait_event(base, 200, "relb_press");
    repeat (10) @(posedge clk);
    set_key(6, 1'b0);
    repeat (2) @(posedge clk);
    set_key(6, 1'b1);
    @(posedge clk);
    set_key(6, 1'b0);
    check_drop("relb");
    repeat (20) @(posedge clk);
    check("relb_single_event", ev_cnt, base + 1);

    // '1' and '3' together are ambiguous; then '0' alone.
    base = ev_cnt;
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("dual_no_event", ev_cnt, base);
    check("dual_not_held", kif.key_held, 32'd0);
    pressed[0] = 1'b0;
    pressed[2] = 1'b0;
    exp_q.push_back(4'h0);
    set_key(10, 1'b1);
    wait_event(base, 200, "zero_press");
    @(negedge clk);
    check("zero_code", kif.key_code, 32'h0);
    repeat (20) @(posedge clk);
    check("zero_single_event", ev_cnt, base + 1);
    set_key(10, 1'b0);
    wait_held_low(100, "zero");

    // Hold '2', press '9' meanwhile, release '2' -> '9' accepted afterwards.
    base = ev_cnt;
    exp_q.push_back(4'h2);
    set_key(1, 1'b1);
    wait_event(base, 200, "two_press");
    set_key(8, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("nine_hidden_no_event", ev_cnt, base + 1);
    check("nine_hidden_held", kif.key_held, 32'd1);
    check("nine_hidden_code", kif.key_code, 32'h2);
    exp_q.push_back(4'h9);
    set_key(1, 1'b0);
    wait_event(base + 1, 200, "nine_press");
    @(negedge clk);
    check("nine_code", kif.key_code, 32'h9);
    set_key(8, 1'b0);
    wait_held_low(100, "nine");

    // Reset during debounce of '4'; key still down afterwards.
    base = ev_cnt;
    set_key(3, 1'b1);
    run = 0;
    n = 0;
    while (run < 5 && n < 200) begin
      @(negedge clk);
      run = (kif.r_sel === 4'b1101) ? run + 1 : 0;
      n++;
    end
    check("rst4_debounce_reached", run, 32'd5);
    check("rst4_no_event_yet", ev_cnt, base);
    reset = 1'b0;
    #1;
    check("rst4_r_sel", kif.r_sel, 32'hE);
    check("rst4_key_valid", kif.key_valid, 32'd0);
    check("rst4_key_held", kif.key_held, 32'd0);
    check("rst4_key_code", kif.key_code, 32'h0);
    repeat (2) @(negedge clk);
    check("rst4_no_event_in_reset", ev_cnt, base);
    reset = 1'b1;
    exp_q.push_back(4'h4);
    wait_event(base, 200, "rst4_press");
    @(negedge clk);
    check("rst4_code", kif.key_code, 32'h4);
    set_key(3, 1'b0);
    wait_held_low(100, "rst4");
    repeat (20) @(posedge clk);
    check("rst4_single_event", ev_cnt, base + 1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
